mem_wb_sequencer: RTL

- Multi-cycle controller for the memory/writeback path of the RISC-V core.
- Accepts one instruction descriptor from the MEM stage.
- Runs a req/ready handshake with data memory for loads and stores, and stalls upstream while an access is pending.
- Drives the 2-bit writeback result-select (00 ALU result, 01 memory read data, 10 PC+4), the register-write enable, the destination register, and the captured load data.

---
 rtl/mem_wb_sequencer.sv | 114 +++++++++++
 1 files changed

// File: rtl/mem_wb_sequencer.sv
// MEM/WB controller: ALU/JUMP writeback one cycle after accept; LOAD/STORE run a req/ready access then one WB cycle.
// Upstream stall is high from LOAD/STORE accept through WB, and in ERR until err_clr.
module mem_wb_sequencer #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   input  logic [1:0]  op_type,
   input  logic [4:0]  op_rd,
   input  logic        op_reg_write,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   input  logic        err_clr,
   output logic        mem_req,
   output logic        mem_we,
   output logic        stall,
   output logic        wb_en,
   output logic [4:0]  wb_rd,
   output logic [1:0]  result_src,
   output logic [31:0] load_data,
   output logic        err
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_STORE = 2'b11;

   typedef enum logic [1:0] {IDLE, ACCESS, WB, ERR} state_t;

   state_t          state, state_nxt;
   logic [1:0]      type_q;
   logic [4:0]      rd_q;
   logic            rw_q;
   logic            alu_wb_q;
   logic [CW-1:0]   cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // op_type[0] set means LOAD or STORE, i.e. a memory access.
   always_comb begin
      state_nxt  = state;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      stall      = 1'b0;
      err        = 1'b0;
      wb_en      = 1'b0;
      wb_rd      = 5'd0;
      result_src = 2'b00;
      if (alu_wb_q && rw_q) begin
         wb_en      = 1'b1;
         wb_rd      = rd_q;
         result_src = type_q;
      end
      case (state)
         IDLE: begin
            if (op_valid && op_type[0]) begin
               stall     = 1'b1;
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            mem_req = 1'b1;
            mem_we  = (type_q == OP_STORE);
            stall   = 1'b1;
            if (mem_ready)          state_nxt = WB;
            else if (cnt_q == LAST) state_nxt = ERR;
         end
         WB: begin
            stall     = 1'b1;
            state_nxt = IDLE;
            if (type_q == OP_LOAD && rw_q) begin
               wb_en      = 1'b1;
               wb_rd      = rd_q;
               result_src = 2'b01;
            end
         end
         ERR: begin
            stall = 1'b1;
            err   = 1'b1;
            if (err_clr) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         type_q    <= 2'b00;
         rd_q      <= 5'd0;
         rw_q      <= 1'b0;
         alu_wb_q  <= 1'b0;
         cnt_q     <= '0;
         load_data <= 32'd0;
      end else begin
         alu_wb_q <= (state == IDLE) && op_valid && !op_type[0];
         if (state == IDLE && op_valid) begin
            type_q <= op_type;
            rd_q   <= op_rd;
            rw_q   <= op_reg_write;
         end
         // Held at zero in IDLE so every access starts its timeout from 0.
         if (state == IDLE)
            cnt_q <= '0;
         else if (state == ACCESS && !mem_ready)
            cnt_q <= cnt_q + CW'(1);
         if (state == ACCESS && mem_ready && type_q == OP_LOAD)
            load_data <= mem_rdata;
      end
   end
endmodule
